// File: rtl/mult_issue_ctrl.sv
// rtl/mult_issue_ctrl.sv - operand issue and result FIFO around the carry-save multiplier
//
// Issues one operand pair at a time to an external multiplier that has no
// handshake, holds the operands while the registered product settles, samples
// the product SETTLE edges after the load and buffers it in a small FIFO.
//
// Optional build macro: MULT_CHECK_EN (adds chk_err / err_cnt and compares
// the product against the multiplier's verification output on every sample).
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   operand pair handshake, in_a/in_b operands
//   mul_a, mul_b        registered operands to the multiplier
//   mul_p, mul_v        product and verification product from the multiplier
//   out_valid/out_ready result handshake, out_p head-of-FIFO product
//   busy                an operation is in flight
//   op_count            products pushed since reset (wraps)
//   chk_err, err_cnt    sticky mismatch flag and saturating count (MULT_CHECK_EN)
module mult_issue_ctrl #(
  parameter int SIZE       = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int SETTLE     = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [SIZE-1:0]   in_a,
  input  logic [SIZE-1:0]   in_b,
  output logic [SIZE-1:0]   mul_a,
  output logic [SIZE-1:0]   mul_b,
  input  logic [2*SIZE-1:0] mul_p,
  input  logic [2*SIZE-1:0] mul_v,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2*SIZE-1:0] out_p,
  output logic              busy,
  output logic [15:0]       op_count
`ifdef MULT_CHECK_EN
  ,
  output logic              chk_err,
  output logic [7:0]        err_cnt
`endif
);

  localparam int CW   = ($clog2(SETTLE) < 1) ? 1 : $clog2(SETTLE);
  localparam int AW   = ($clog2(FIFO_DEPTH) < 1) ? 1 : $clog2(FIFO_DEPTH);
  localparam int CNTW = AW + 1;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            load;
  logic            push;
  logic            pop;

  logic [2*SIZE-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CNTW-1:0]   fifo_count;

  // Room is checked here, at acceptance; with a single op in flight the
  // later push can therefore never find the FIFO full.
  assign in_ready  = (state_q == IDLE) && (fifo_count < CNTW'(FIFO_DEPTH)) && !rst;
  assign out_valid = (fifo_count != '0) && !rst;
  assign out_p     = (fifo_count != '0) ? mem[rd_ptr] : '0;
  assign busy      = (state_q != IDLE);
  assign pop       = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    push    = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          load    = 1'b1;
          cnt_d   = CW'(SETTLE - 1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          push    = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mul_a   <= '0;
      mul_b   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (load) begin
        mul_a <= in_a;
        mul_b <= in_b;
      end
    end
  end

  // Storage is not reset; out_p is forced to zero whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem[wr_ptr] <= mul_p;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      op_count   <= '0;
    end else begin
      if (push) begin
        wr_ptr   <= wr_ptr + AW'(1);
        op_count <= op_count + 16'd1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNTW'(1);
        2'b01:   fifo_count <= fifo_count - CNTW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

`ifdef MULT_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      chk_err <= 1'b0;
      err_cnt <= '0;
    end else if (push && (mul_p != mul_v)) begin
      chk_err <= 1'b1;
      if (err_cnt != 8'hFF) begin
        err_cnt <= err_cnt + 8'd1;
      end
    end
  end
`else
  // The verification product is only consumed by the checker build.
  logic unused_mul_v;
  assign unused_mul_v = ^mul_v;
`endif

endmodule

// File: doc/mult_issue_ctrl.md
Name: mult_issue_ctrl

Overview:
Operand-issue and result-collection stage wrapped around the parallel carry-save multiplier.
- Accepts operand pairs over a valid/ready handshake.
- Drives the multiplier's operand inputs and holds them stable until the registered product has settled.
- Samples the product and buffers it in a small result FIFO with a valid/ready output.
- Lets the multiplier, which has no handshake of its own, feed a streaming datapath.

Parameters:
SIZE, 16, operand width in bits; must equal the multiplier's size setting.
FIFO_DEPTH, 4, result FIFO entries; power of two, >= 2.
SETTLE, 2, clock edges from operand load to product sample; >= 2.

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
in_valid  in  1  operand pair valid
in_ready  out  1  block can accept an operand pair
in_a  in  SIZE  multiplicand
in_b  in  SIZE  multiplier
mul_a  out  SIZE  registered operand to multiplier a
mul_b  out  SIZE  registered operand to multiplier b
mul_p  in  2*SIZE  product from multiplier p
mul_v  in  2*SIZE  verification product from multiplier v (used only with MULT_CHECK_EN)
out_valid  out  1  FIFO head holds a product
out_ready  in  1  consumer accepts head
out_p  out  2*SIZE  FIFO head product
busy  out  1  operation in flight (state != IDLE)
op_count  out  16  products pushed to FIFO since reset, wraps 0xFFFF->0

Behaviour:
Reset and clocking:
- One clock, clk; rst synchronous active-high.
- At any edge with rst=1: state=IDLE, mul_a=mul_b=0, FIFO emptied, op_count=0, err state cleared.
- While rst=1: in_ready=0, out_valid=0.
- rst mid-operation discards the in-flight operation and all buffered results; no partial push.

State machine:
- Two states: IDLE, WAIT. Down-counter cnt, width ceil(log2(SETTLE)).
- in_ready = (state==IDLE) && (fifo_count < FIFO_DEPTH) && !rst; combinational.
- IDLE, edge with in_valid && in_ready:
  - mul_a <= in_a, mul_b <= in_b.
  - cnt <= SETTLE-1; state <= WAIT.
- WAIT, cnt != 0: cnt decrements each edge; mul_a/mul_b held constant.
- WAIT, cnt == 0, at that edge:
  - mul_p is pushed into the FIFO; op_count increments.
  - state <= IDLE.
- Sample edge is load edge + SETTLE. Default 2: the multiplier registers its upper product half on edge +1; the full product is stable for edge +2.

Timing:
- out_valid first rises in the cycle after the sample edge.
- Minimum in->out latency: SETTLE+1 cycles.
- Throughput: one op per SETTLE+1 cycles; no acceptance in WAIT.
- mul_a/mul_b retain the last operands while IDLE; no spurious toggling.

FIFO:
- Room is checked at acceptance and only one op is ever in flight, so a push never finds the FIFO full.
- Pop on edge with out_valid && out_ready.
- Push and pop on the same edge: count unchanged; ordering preserved.
- out_p = head entry; stable while out_valid && !out_ready.
- out_p = 0 when empty.
- Pointer wrap modulo FIFO_DEPTH.

Width rules:
- Product is exactly 2*SIZE bits; unsigned; no truncation.

Optional Feature:
Macro MULT_CHECK_EN.
- Defined:
  - Extra output ports chk_err (1, sticky) and err_cnt (8, saturating at 0xFF).
  - On each sample edge, if mul_p != mul_v: chk_err <= 1 and err_cnt increments.
  - The mismatching product is still pushed unchanged.
  - Both cleared only by rst.
- Undefined:
  - Ports absent; mul_v input left unconnected internally.
  - No compare logic synthesised.

Test Plan:
- Single op: in_a=3, in_b=5 handshake at edge E0 -> mul_a=3, mul_b=5 after E0; out_valid=1 after E2; out_p=0x0000000F; op_count=1.
- Max operands: 0xFFFF x 0xFFFF -> out_p=0xFFFE0001; 0x0000 x 0x1234 -> out_p=0.
- Backpressure: out_ready=0, push 4 ops (2x2, 3x3, 4x4, 5x5) -> in_ready=0 after 4th sample; then out_ready=1 -> outputs 4, 9, 16, 25 in order; in_ready returns 1 after the first pop.
- Simultaneous push/pop: FIFO holding 1 entry, out_ready=1 on the sample edge of 7x6 -> count stays 1; next head out_p=42.
- Reset mid-op: rst asserted one cycle after accepting 10x10 with 2 entries buffered -> out_valid=0, op_count=0, in_ready=1 the cycle after rst falls; no 100 ever emitted.
- MULT_CHECK_EN: force mul_v=0 for op 9x9 -> chk_err=1, err_cnt=1, out_p=81; holds after the next matching op; cleared by rst.
